// File: rtl/msrv32_fetch_stage.sv
// rtl/msrv32_fetch_stage.sv - fetch PC, pipelined imem requests, instruction buffer toward decode
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect target pulses misaligned_out and halts fetch.
module msrv32_fetch_stage #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        redirect_in,
  input  logic [31:0] pc_mux_in,
  output logic [31:0] pc_out,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        misaligned_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] fifo_instr [FIFO_DEPTH];
  logic [31:0] fifo_pc    [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic        outstanding;
  logic [31:0] out_pc;
  logic        kill;
  logic        halt;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        pop;
  logic        accept;
  logic        complete;
  logic        push;
  logic [CW:0] occupancy;

  assign clk = ms_riscv32_mp_clk_in;
  assign rst = ms_riscv32_mp_rst_in;

  assign valid     = !rst && (count != '0);
  assign pop       = valid && instr_ready_in;
  // Counting the same-cycle pop lets a full buffer still fetch every cycle.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, outstanding} - {{CW{1'b0}}, pop};

  assign imem_req_out  = !rst && !redirect_in && !halt && (occupancy < DEPTH_V);
  assign imem_addr_out = pc;
  assign pc_out        = pc;

  assign accept   = imem_req_out && imem_ready_in;
  assign complete = outstanding && imem_ready_in;
  assign push     = complete && !kill && !redirect_in;

  assign instr_valid_out = valid;
  assign instr_out       = valid ? fifo_instr[rd_ptr] : 32'h0000_0013;
  assign instr_pc_out    = valid ? fifo_pc[rd_ptr]    : 32'h0000_0000;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misaligned_q;

  assign redirect_pc    = pc_mux_in;
  assign misaligned_out = misaligned_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      halt         <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= redirect_in && (pc_mux_in[1:0] != 2'b00);
      if (redirect_in) begin
        halt <= (pc_mux_in[1:0] != 2'b00);
      end
    end
  end
`else
  logic unused_low_bits;

  assign unused_low_bits = ^pc_mux_in[1:0];
  assign redirect_pc     = {pc_mux_in[31:2], 2'b00};
  assign halt            = 1'b0;
  assign misaligned_out  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= BOOT_ADDRESS;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      out_pc      <= 32'h0;
      kill        <= 1'b0;
    end else if (redirect_in) begin
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // A response still in flight must be swallowed when it finally arrives.
      if (outstanding && !imem_ready_in) begin
        kill <= 1'b1;
      end else if (complete) begin
        outstanding <= 1'b0;
        kill        <= 1'b0;
      end
    end else begin
      if (accept) begin
        pc     <= pc + 32'd4;
        out_pc <= pc;
      end
      if (complete) begin
        kill <= 1'b0;
      end
      if (accept) begin
        outstanding <= 1'b1;
      end else if (complete) begin
        outstanding <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata_in;
      fifo_pc[wr_ptr]    <= out_pc;
    end
  end

endmodule

// File: doc/msrv32_fetch_stage.md
# msrv32_fetch_stage

Instruction fetch stage between the PC mux and the decode stage. Holds the architectural fetch PC, issues pipelined requests to instruction memory, and buffers returned words with their PCs in a small FIFO toward decode. Redirects (branch/trap/mret) load the PC mux result, flush the buffer, and squash any in-flight response.

## Interface
Parameters:
- BOOT_ADDRESS, 32'h0000_0000, PC value loaded at reset
- FIFO_DEPTH, 4, instruction buffer entries (power of two, ≥2)

Ports:
- ms_riscv32_mp_clk_in  in  1  clock; all state updates on the rising edge
- ms_riscv32_mp_rst_in  in  1  synchronous, active-high reset
- redirect_in  in  1  load pc_mux_in into the PC and flush
- pc_mux_in  in  32  redirect target from the PC mux
- pc_out  out  32  current fetch PC, fed back to the PC mux pc_in
- imem_req_out  out  1  address-phase request
- imem_addr_out  out  32  address-phase address (equals pc_out)
- imem_ready_in  in  1  memory ready; completes the data phase and accepts the address phase
- imem_rdata_in  in  32  data-phase instruction word
- instr_valid_out  out  1  FIFO head valid
- instr_ready_in  in  1  decode accepts the head
- instr_out  out  32  head instruction; 32'h0000_0013 when empty
- instr_pc_out  out  32  head PC; 0 when empty
- misaligned_out  out  1  fetch-target misaligned pulse (see Configuration)

## Operation
- State: pc, FIFO (storage, rd/wr pointers, count), outstanding flag and its PC, kill flag, halt flag.
- imem_req_out = !rst & !redirect_in & !halt & (count + outstanding − pop < FIFO_DEPTH), where pop = instr_valid_out & instr_ready_in. The pop lookahead allows one fetch per cycle at full throughput.
- Accept (edge with imem_req_out & imem_ready_in):
  - outstanding ← 1
  - outstanding PC ← pc
  - pc ← pc + 4, wrapping modulo 2^32
- Complete (edge with outstanding & imem_ready_in):
  - Push {imem_rdata_in, outstanding PC} unless kill or redirect_in.
  - kill ← 0.
  - outstanding ← 0, unless an accept happens on the same edge.
- Pop and push on the same edge: count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Overflow cannot occur, because the request gating guarantees space.
- Redirect (edge with redirect_in):
  - pc ← pc_mux_in
  - FIFO cleared (count and pointers ← 0)
  - No accept is possible, since req is forced low.
  - If outstanding & !imem_ready_in: kill ← 1 and outstanding stays 1.
  - If outstanding & imem_ready_in: the returning data is dropped.
  - Redirect takes priority over push and pop on the same edge.
- imem_ready_in low: no accept and no complete; all state is held except redirect effects.

## Timing
- Reset values: pc = BOOT_ADDRESS, count = 0, outstanding = 0, kill = 0, halt = 0.
- Outputs during reset: imem_req_out = 0, instr_valid_out = 0, instr_out = 32'h13, instr_pc_out = 0, misaligned_out = 0.
- Reset asserted mid-transfer abandons the outstanding response. Memory data returned after reset is ignored, because outstanding = 0.
- Latency with imem_ready_in = 1:
  - Request in cycle C; word visible on instr_valid_out in cycle C+2.
  - First request in the first cycle after reset deasserts.
  - Redirect in cycle N: request to target in N+1, valid in N+3. No pre-redirect instruction is visible after N.
- Steady-state throughput: one instruction per cycle while decode accepts every cycle.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - On a redirect edge with pc_mux_in[1:0] ≠ 0: misaligned_out pulses high for one cycle (the cycle after the edge), halt ← 1, and pc ← pc_mux_in unmodified.
  - While halted, imem_req_out = 0. The next redirect clears halt.
- FETCH_MISALIGN_CHK_EN undefined:
  - pc ← {pc_mux_in[31:2], 2'b00} on redirect.
  - misaligned_out is tied 0 and halt is never set.

## Test plan
- Reset release, ready = 1, rdata = address-derived word, decode always ready → instr_pc_out sequence 0, 4, 8… with valid from cycle 2, one per cycle.
- Decode stalled (instr_ready_in = 0) for 10 cycles → exactly 4 entries buffered, imem_req_out low once count + outstanding = 4, no loss or duplication after release.
- imem_ready_in held low 3 cycles mid-stream → pc, outstanding and FIFO frozen; stream resumes in order with no gap or duplicate.
- Redirect to 32'h100 with an outstanding request and imem_ready_in = 0 → stale word dropped when ready rises; next visible instr_pc_out = 32'h100 at N+3.
- Redirect on the same edge as push and pop → FIFO empty the next cycle; 32'h13 and 0 on the outputs.
- Redirect to 32'h102:
  - Macro defined → misaligned_out high one cycle and no requests until a redirect to 32'h200 resumes fetching there.
  - Macro undefined → fetching proceeds from 32'h100.
